// File: rtl/candy_div_if.sv
// Handshake and operand bundle between candy_alu (requester) and the candy_div sequencer.
interface candy_div_if #(
  parameter int WIDTH = 24
);
  logic             signed_div_i;
  logic [WIDTH-1:0] opdata1_i;
  logic [WIDTH-1:0] opdata2_i;
  logic             start_i;
  logic             annul_i;
  logic [WIDTH-1:0] result_o;
  logic [WIDTH-1:0] remainder_o;
  logic             ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, remainder_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, remainder_o, ready_o
  );
endinterface

// File: rtl/candy_div.sv
// Radix-2 restoring divider for the ALU's DIV/DIVU ops: one quotient bit per cycle,
// signed via magnitude division plus sign fix-up, with divide-by-zero and annul handling.
module candy_div #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  candy_div_if.slave  div
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] dvd, dvd_nxt;
  logic [WIDTH-1:0] dsr, dsr_nxt;
  logic [WIDTH-1:0] rem, rem_nxt;
  logic             q_neg, q_neg_nxt;
  logic             r_neg, r_neg_nxt;
  logic [WIDTH-1:0] result_q, result_nxt;
  logic [WIDTH-1:0] remainder_q, remainder_nxt;
  logic             ready_q, ready_nxt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             qbit;

  // Most negative value maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    return (v < 0) ? unsigned'(-v) : unsigned'(v);
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? ((~v) + WIDTH'(1)) : v;
  endfunction

  // One restoring step: partial remainder stays below the divisor, so the
  // difference always fits in WIDTH bits whenever it is kept.
  always_comb begin
    shifted = {rem, dvd[WIDTH-1]};
    qbit    = (shifted >= {1'b0, dsr});
    diff    = shifted[WIDTH-1:0] - dsr;
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    dvd_nxt       = dvd;
    dsr_nxt       = dsr;
    rem_nxt       = rem;
    q_neg_nxt     = q_neg;
    r_neg_nxt     = r_neg;
    result_nxt    = result_q;
    remainder_nxt = remainder_q;
    ready_nxt     = ready_q;

    case (state)
      FREE: begin
        ready_nxt     = 1'b0;
        result_nxt    = '0;
        remainder_nxt = '0;
        if (div.start_i && !div.annul_i) begin
          if (div.opdata2_i == '0) begin
            state_nxt = BYZERO;
          end else begin
            state_nxt = ON;
            cnt_nxt   = '0;
            rem_nxt   = '0;
            if (div.signed_div_i) begin
              dvd_nxt   = magnitude($signed(div.opdata1_i));
              dsr_nxt   = magnitude($signed(div.opdata2_i));
              q_neg_nxt = div.opdata1_i[WIDTH-1] ^ div.opdata2_i[WIDTH-1];
              r_neg_nxt = div.opdata1_i[WIDTH-1];
            end else begin
              dvd_nxt   = div.opdata1_i;
              dsr_nxt   = div.opdata2_i;
              q_neg_nxt = 1'b0;
              r_neg_nxt = 1'b0;
            end
          end
        end
      end

      BYZERO: begin
        state_nxt     = END;
        ready_nxt     = 1'b1;
        result_nxt    = '0;
        remainder_nxt = '0;
      end

      ON: begin
        if (div.annul_i) begin
          state_nxt = FREE;
        end else if (cnt != CNT_W'(WIDTH)) begin
          rem_nxt = qbit ? diff : shifted[WIDTH-1:0];
          dvd_nxt = {dvd[WIDTH-2:0], qbit};
          cnt_nxt = cnt + CNT_W'(1);
        end else begin
          // dvd now holds the unsigned quotient, rem the unsigned remainder.
          result_nxt    = apply_sign(dvd, q_neg);
          remainder_nxt = apply_sign(rem, r_neg);
          ready_nxt     = 1'b1;
          state_nxt     = END;
        end
      end

      END: begin
        if (!div.start_i || div.annul_i) begin
          state_nxt     = FREE;
          ready_nxt     = 1'b0;
          result_nxt    = '0;
          remainder_nxt = '0;
        end
      end

      default: state_nxt = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FREE;
      cnt         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      dvd         <= dvd_nxt;
      dsr         <= dsr_nxt;
      rem         <= rem_nxt;
      q_neg       <= q_neg_nxt;
      r_neg       <= r_neg_nxt;
      result_q    <= result_nxt;
      remainder_q <= remainder_nxt;
      ready_q     <= ready_nxt;
    end
  end

  assign div.result_o    = result_q;
  assign div.remainder_o = remainder_q;
  assign div.ready_o     = ready_q;

endmodule

// File: tb/tb_candy_div.sv
// Directed bench for candy_div: latency, signed/unsigned results, divide-by-zero,
// annul, operand stability and asynchronous reset.
module tb_candy_div;
  localparam int WIDTH = 24;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  candy_div_if #(.WIDTH(WIDTH)) bus ();

  candy_div #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .div (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts an op, checks ready stays low through E24 and rises after E25 with the result.
  task automatic run_div(input string tag, input logic sgn, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] q,
                         input logic [WIDTH-1:0] r, input logic scramble);
    logic early;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    step();
    if (scramble) begin
      bus.opdata1_i    = ~a;
      bus.opdata2_i    = 24'h000001;
      bus.signed_div_i = ~sgn;
    end
    early = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (bus.ready_o !== 1'b0) early = 1'b1;
    end
    chk({tag, "_early_ready"}, WIDTH'(early), '0);
    step();
    chk({tag, "_ready"}, WIDTH'(bus.ready_o), WIDTH'(1));
    chk({tag, "_quot"}, bus.result_o, q);
    chk({tag, "_rem"}, bus.remainder_o, r);
  endtask

  task automatic release_op(input string tag);
    bus.start_i = 1'b0;
    step();
    chk({tag, "_rel_ready"}, WIDTH'(bus.ready_o), '0);
    chk({tag, "_rel_quot"}, bus.result_o, '0);
    chk({tag, "_rel_rem"}, bus.remainder_o, '0);
  endtask

  initial begin
    logic changed;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;

    // Reset state
    step();
    step();
    chk("reset_ready", WIDTH'(bus.ready_o), '0);
    chk("reset_quot", bus.result_o, '0);
    chk("reset_rem", bus.remainder_o, '0);
    rst = 1'b1;
    step();

    // Unsigned 100 / 7, then hold start in END for 10 cycles
    run_div("u100_7", 1'b0, 24'h000064, 24'h000007, 24'h00000E, 24'h000002, 1'b0);
    changed = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.ready_o !== 1'b1 || bus.result_o !== 24'h00000E || bus.remainder_o !== 24'h000002)
        changed = 1'b1;
    end
    chk("u100_7_hold_stable", WIDTH'(changed), '0);
    release_op("u100_7");

    run_div("s_m100_7", 1'b1, 24'hFFFF9C, 24'h000007, 24'hFFFFF2, 24'hFFFFFE, 1'b0);
    release_op("s_m100_7");
    run_div("s_100_m7", 1'b1, 24'h000064, 24'hFFFFF9, 24'hFFFFF2, 24'h000002, 1'b0);
    release_op("s_100_m7");
    run_div("s_m7_m2", 1'b1, 24'hFFFFF9, 24'hFFFFFE, 24'h000003, 24'hFFFFFF, 1'b0);
    release_op("s_m7_m2");
    run_div("u_fff9c_7", 1'b0, 24'hFFFF9C, 24'h000007, 24'h24923A, 24'h000006, 1'b0);
    release_op("u_fff9c_7");

    // Divide by zero
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 24'h123456;
    bus.opdata2_i    = 24'h000000;
    bus.start_i      = 1'b1;
    step();
    chk("dbz_e0_ready", WIDTH'(bus.ready_o), '0);
    step();
    chk("dbz_e1_ready", WIDTH'(bus.ready_o), WIDTH'(1));
    chk("dbz_quot", bus.result_o, '0);
    chk("dbz_rem", bus.remainder_o, '0);
    release_op("dbz");

    run_div("s_ovf", 1'b1, 24'h800000, 24'hFFFFFF, 24'h800000, 24'h000000, 1'b0);
    release_op("s_ovf");
    run_div("u_max", 1'b0, 24'hFFFFFF, 24'h000001, 24'hFFFFFF, 24'h000000, 1'b0);
    release_op("u_max");

    // Operands changed during ON must be ignored
    run_div("stable_ops", 1'b0, 24'h000200, 24'h000010, 24'h000020, 24'h000000, 1'b1);
    release_op("stable_ops");

    // Annul at iteration 10, then immediate restart
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 24'h0003E8;
    bus.opdata2_i    = 24'h000003;
    bus.start_i      = 1'b1;
    step();
    for (int i = 0; i < 10; i++) step();
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    step();
    bus.annul_i = 1'b0;
    chk("annul_ready", WIDTH'(bus.ready_o), '0);
    run_div("restart_9_3", 1'b0, 24'h000009, 24'h000003, 24'h000003, 24'h000000, 1'b0);
    release_op("restart_9_3");

    // Async reset at iteration 5, start kept high, then a full fresh operation
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 24'h000050;
    bus.opdata2_i    = 24'h000005;
    bus.start_i      = 1'b1;
    step();
    for (int i = 0; i < 5; i++) step();
    #1 rst = 1'b0;
    #1 chk("rst_mid_ready", WIDTH'(bus.ready_o), '0);
    chk("rst_mid_quot", bus.result_o, '0);
    #1 rst = 1'b1;
    run_div("after_rst", 1'b0, 24'h0000FF, 24'h000010, 24'h00000F, 24'h00000F, 1'b0);

    // Async reset while results are displayed in END clears outputs before any edge
    #1 rst = 1'b0;
    #1 chk("rst_end_ready", WIDTH'(bus.ready_o), '0);
    chk("rst_end_quot", bus.result_o, '0);
    chk("rst_end_rem", bus.remainder_o, '0);
    #1 rst = 1'b1;
    bus.start_i = 1'b0;
    step();
    chk("rst_end_idle_ready", WIDTH'(bus.ready_o), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
